// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter/sequencer that loads one shared WIDTH-bit register from NREQ requesters.
// Optional forced release of a stuck winner is enabled by defining ARB_TIMEOUT_EN.
module dff_bank_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NREQ-1:0]         Req,
    input  logic [NREQ*WIDTH-1:0]   D,
    output logic [NREQ-1:0]         Grant,
    output logic [WIDTH-1:0]        Q,
    output logic                    Wr_Done,
    output logic [IDW-1:0]          Last_Id,
    output logic                    Busy,
    output logic                    Timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t             r_state;
    logic [NREQ-1:0]    r_grant;
    logic [WIDTH-1:0]   r_q;
    logic               r_wr_done;
    logic [IDW-1:0]     r_last_id;
    logic               r_busy;

    logic               w_found;
    logic [IDW-1:0]     w_winner;
    logic [NREQ-1:0]    w_onehot;
    logic [WIDTH-1:0]   w_slice;
    logic               w_req_w;

    // Scan from the farthest offset down so the nearest requester after Last_Id wins.
    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_id;
        for (int k = NREQ; k >= 1; k--) begin
            if (Req[(int'(r_last_id) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = IDW'((int'(r_last_id) + k) % NREQ);
            end
        end
    end

    assign w_onehot = NREQ'(1) << w_winner;

    // Last_Id holds the current winner from LOAD onward.
    assign w_slice = D[int'(r_last_id)*WIDTH +: WIDTH];
    assign w_req_w = Req[r_last_id];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_timeout;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_q       <= '0;
            r_wr_done <= 1'b0;
            r_last_id <= IDW'(NREQ - 1);
            r_busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_wr_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant   <= w_onehot;
                        r_last_id <= w_winner;
                        r_busy    <= 1'b1;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    // The load happens even if the winner already dropped Req.
                    r_q       <= w_slice;
                    r_wr_done <= 1'b1;
                    r_state   <= WAIT_REL;
`ifdef ARB_TIMEOUT_EN
                    r_cnt     <= '0;
`endif
                end
                WAIT_REL: begin
                    if (!w_req_w) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
`ifdef ARB_TIMEOUT_EN
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Grant   = r_grant;
    assign Q       = r_q;
    assign Wr_Done = r_wr_done;
    assign Last_Id = r_last_id;
    assign Busy    = r_busy;
`ifdef ARB_TIMEOUT_EN
    assign Timeout = r_timeout;
`else
    assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: single-transaction vector table plus rotation,
// reset-in-LOAD, early-drop and stuck-winner sequences.
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  Clk = 1'b0;
    logic                  Reset;
    logic [NREQ-1:0]       Req;
    logic [NREQ*WIDTH-1:0] D;
    logic [NREQ-1:0]       Grant;
    logic [WIDTH-1:0]      Q;
    logic                  Wr_Done;
    logic [1:0]            Last_Id;
    logic                  Busy;
    logic                  Timeout;

    int total = 0;
    int bad   = 0;

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(16)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .D       (D),
        .Grant   (Grant),
        .Q       (Q),
        .Wr_Done (Wr_Done),
        .Last_Id (Last_Id),
        .Busy    (Busy),
        .Timeout (Timeout)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] d;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_q;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req   = '0;
        #3;
        Reset = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        Req = v.req;
        D   = v.d;
        tick();
        check($sformatf("v%0d grant", idx), 32'(Grant), 32'(v.exp_grant));
        check($sformatf("v%0d last_id", idx), 32'(Last_Id), 32'(v.exp_id));
        check($sformatf("v%0d busy", idx), 32'(Busy), 32'd1);
        tick();
        check($sformatf("v%0d q", idx), 32'(Q), 32'(v.exp_q));
        check($sformatf("v%0d wr_done", idx), 32'(Wr_Done), 32'd1);
        tick();
        check($sformatf("v%0d wr_done_end", idx), 32'(Wr_Done), 32'd0);
        check($sformatf("v%0d grant_held", idx), 32'(Grant), 32'(v.exp_grant));
        Req = '0;
        tick();
        check($sformatf("v%0d grant_rel", idx), 32'(Grant), 32'd0);
        check($sformatf("v%0d busy_rel", idx), 32'(Busy), 32'd0);
        check($sformatf("v%0d q_hold", idx), 32'(Q), 32'(v.exp_q));
    endtask

    initial begin
        logic [7:0] slices[4];
        int order[5];
        int cnt;

        Reset = 1'b1;
        Req   = '0;
        D     = '0;

        // Slices packed as {s3, s2, s1, s0}.
        vecs[0] = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5, 2'd0};
        vecs[1] = '{4'b0100, 32'h00C30000, 4'b0100, 8'hC3, 2'd2};
        vecs[2] = '{4'b1010, 32'hD300B100, 4'b1000, 8'hD3, 2'd3};
        vecs[3] = '{4'b1010, 32'hD300B100, 4'b0010, 8'hB1, 2'd1};
        vecs[4] = '{4'b1001, 32'h09000001, 4'b1000, 8'h09, 2'd3};
        vecs[5] = '{4'b0011, 32'h00002277, 4'b0001, 8'h77, 2'd0};
        vecs[6] = '{4'b1111, 32'h44335C11, 4'b0010, 8'h5C, 2'd1};
        vecs[7] = '{4'b1000, 32'hFE000000, 4'b1000, 8'hFE, 2'd3};
        vecs[8] = '{4'b0010, 32'h12340056, 4'b0010, 8'h00, 2'd1};
        vecs[9] = '{4'b0100, 32'h00FF0000, 4'b0100, 8'hFF, 2'd2};

        #2;
        check("rst grant", 32'(Grant), 32'd0);
        check("rst q", 32'(Q), 32'd0);
        check("rst wr_done", 32'(Wr_Done), 32'd0);
        check("rst last_id", 32'(Last_Id), 32'd3);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst timeout", 32'(Timeout), 32'd0);
        Reset = 1'b0;
        tick();
        tick();
        check("idle no req", 32'(Grant), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Continuous Req=1111 rotation: winners re-raise two cycles after dropping.
        do_reset();
        D = 32'h44332211;
        slices = '{8'h11, 8'h22, 8'h33, 8'h44};
        order  = '{0, 1, 2, 3, 0};
        Req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            cnt = 0;
            while (Grant == '0 && cnt < 10) begin
                tick();
                cnt++;
            end
            check($sformatf("rot%0d grant", r), 32'(Grant), 32'(4'b0001 << order[r]));
            tick();
            check($sformatf("rot%0d q", r), 32'(Q), 32'(slices[order[r]]));
            check($sformatf("rot%0d wr_done", r), 32'(Wr_Done), 32'd1);
            Req[order[r]] = 1'b0;
            tick();
            check($sformatf("rot%0d rel", r), 32'(Grant), 32'd0);
            tick();
            Req[order[r]] = 1'b1;
        end
        Req = '0;
        cnt = 0;
        while (Busy && cnt < 10) begin
            tick();
            cnt++;
        end
        check("rot drain", 32'(Busy), 32'd0);
        tick();

        // Reset asserted while in LOAD.
        Req = 4'b0100;
        D   = 32'h00990066;
        tick();
        check("rl grant", 32'(Grant), 32'b0100);
        #2;
        Reset = 1'b1;
        #1;
        check("rl grant0", 32'(Grant), 32'd0);
        check("rl q0", 32'(Q), 32'd0);
        check("rl wr_done0", 32'(Wr_Done), 32'd0);
        check("rl busy0", 32'(Busy), 32'd0);
        check("rl last_id", 32'(Last_Id), 32'd3);
        #1;
        Reset = 1'b0;
        Req = 4'b0101;
        tick();
        check("rl winner0", 32'(Grant), 32'b0001);
        tick();
        check("rl q", 32'(Q), 32'h66);
        Req = '0;
        tick();
        tick();
        check("rl idle", 32'(Busy), 32'd0);

        // Requester 1 drops Req during LOAD.
        Req = 4'b0010;
        D   = 32'h00005A00;
        tick();
        check("ed grant", 32'(Grant), 32'b0010);
        Req = '0;
        tick();
        check("ed q", 32'(Q), 32'h5A);
        check("ed wr_done", 32'(Wr_Done), 32'd1);
        check("ed grant_load", 32'(Grant), 32'b0010);
        tick();
        check("ed grant_rel", 32'(Grant), 32'd0);
        check("ed busy_rel", 32'(Busy), 32'd0);

        // Winner 3 holds Req indefinitely while requester 0 waits.
        Req = 4'b1001;
        D   = 32'h3C000081;
        tick();
        check("to grant", 32'(Grant), 32'b1000);
        tick();
        check("to q", 32'(Q), 32'h3C);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        check("to held15", 32'(Grant), 32'b1000);
        check("to flag15", 32'(Timeout), 32'd0);
        tick();
        check("to forced", 32'(Grant), 32'd0);
        check("to busy", 32'(Busy), 32'd0);
        check("to flag", 32'(Timeout), 32'd1);
        check("to q_kept", 32'(Q), 32'h3C);
        tick();
        check("to next", 32'(Grant), 32'b0001);
        tick();
        check("to next_q", 32'(Q), 32'h81);
        Req = '0;
        tick();
        tick();
        check("to sticky", 32'(Timeout), 32'd1);
`else
        for (int i = 0; i < 20; i++) tick();
        check("to held", 32'(Grant), 32'b1000);
        check("to flag", 32'(Timeout), 32'd0);
        check("to busy", 32'(Busy), 32'd1);
        Req = '0;
        tick();
        check("to rel", 32'(Grant), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared WIDTH-bit D flip-flop register with a load enable.
- Up to NREQ requesters compete to write the register through a 4-phase Req/Grant handshake.
- The block selects one requester, loads that requester's data slice into the register, then holds Grant until the winner releases Req.
- The register contents drive Q, which downstream logic consumes.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, width of the shared register and of each data slice
TIMEOUT, 16, maximum WAIT_REL cycles before forced release (used only with ARB_TIMEOUT_EN)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Req  input  NREQ  per-requester request, level, held until Grant observed and write done
D  input  NREQ*WIDTH  packed data; slice i = D[i*WIDTH +: WIDTH], stable while Req[i]=1
Grant  output  NREQ  one-hot grant, all-zero when idle
Q  output  WIDTH  shared register contents
Wr_Done  output  1  one-cycle pulse, the cycle after Q is loaded
Last_Id  output  clog2(NREQ)  index of most recent winner
Busy  output  1  high whenever state != IDLE
Timeout  output  1  sticky timeout flag (only with ARB_TIMEOUT_EN, else tied 0)

Behaviour:
- Reset (async, any state):
  - Grant=0, Q=0, Wr_Done=0, Last_Id=NREQ-1, Busy=0, Timeout=0, state=IDLE.
  - The round-robin pointer equals Last_Id, so requester 0 has first priority after reset.
- States: IDLE, LOAD, WAIT_REL; all outputs are registered.
- IDLE, at the clock edge:
  - If Req != 0, winner w = first set Req bit scanning Last_Id+1, Last_Id+2, ... modulo NREQ.
  - Grant <= onehot(w), Last_Id <= w, Busy <= 1, go to LOAD.
  - If Req == 0, remain in IDLE.
- LOAD (exactly 1 cycle):
  - Q <= D slice w at the closing edge.
  - Wr_Done <= 1 for the following cycle only.
  - Go to WAIT_REL.
  - If Req[w] has already dropped, the load still occurs.
- WAIT_REL:
  - Grant held.
  - When Req[w] is sampled 0: Grant <= 0, Busy <= 0, go to IDLE.
  - Minimum idle gap between grants is one cycle.
- Latency: Req sampled in IDLE at edge N gives Grant at N+1, Q updated at N+2, Wr_Done high during cycle N+2 to N+3.
- Other requesters' Req bits are ignored outside IDLE; they stay pending and are served in rotation.
- A requester never receives two consecutive grants while another Req is pending.
- Q holds its value except during LOAD.
- No request is lost or duplicated by the block. A requester that drops Req before being granted is simply not served.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_REL. If Req[w] is still 1 after TIMEOUT cycles in WAIT_REL, force Grant <= 0, Busy <= 0, go to IDLE, and set Timeout=1.
  - Timeout is sticky until Reset.
  - Q is unaffected.
- Undefined:
  - No counter; WAIT_REL waits indefinitely; Timeout tied 0.

Test Plan:
1. Reset, then Req=0001, D slice0=8'hA5 -> Grant=0001 one cycle after sampling; Q=8'hA5 next cycle with Wr_Done pulse; drop Req -> Grant=0000, Busy=0.
2. Req=1111 held continuously, slices 8'h11/22/33/44, each requester drops Req after its Wr_Done and re-raises 2 cycles later -> grant order 0,1,2,3,0; Q sequence 11,22,33,44,11.
3. After requester 2 wins, Req=1010 -> next winner 3, then 1; Last_Id reads 3 then 1.
4. Assert Reset during LOAD with Req=0100 -> Grant=0, Q=0, Wr_Done=0 immediately; after release, Req=0101 -> requester 0 wins.
5. Requester 1 drops Req during LOAD (D=8'h5A) -> Q=8'h5A still loaded, Wr_Done pulses, Grant drops on the next WAIT_REL edge.
6. With ARB_TIMEOUT_EN, TIMEOUT=16: winner holds Req forever -> Grant drops after 16 WAIT_REL cycles, Timeout=1 sticky; the next pending requester is then granted. Without the macro: Grant stays high and Timeout=0.
